// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states,
// access-size decode and common constants.
package lsu_pkg;

  localparam logic [2:0] INST_LB  = 3'b000;
  localparam logic [2:0] INST_LH  = 3'b001;
  localparam logic [2:0] INST_LW  = 3'b010;
  localparam logic [2:0] INST_LBU = 3'b100;
  localparam logic [2:0] INST_LHU = 3'b101;
  localparam logic [2:0] INST_SB  = 3'b000;
  localparam logic [2:0] INST_SH  = 3'b001;
  localparam logic [2:0] INST_SW  = 3'b010;

  localparam logic [31:0] ZERO_WORD     = '0;
  localparam logic        WRITE_ENABLE  = 1'b1;
  localparam logic        WRITE_DISABLE = 1'b0;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_RD   = 2'd1,
    LSU_WR   = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_t;

  // Unknown funct3 encodings fall back to word width.
  function automatic lsu_size_t access_size(input logic we, input logic [2:0] f3);
    lsu_size_t sz;
    sz = SZ_WORD;
    if (we) begin
      case (f3)
        INST_SB: sz = SZ_BYTE;
        INST_SH: sz = SZ_HALF;
        INST_SW: sz = SZ_WORD;
        default: sz = SZ_WORD;
      endcase
    end else begin
      case (f3)
        INST_LB, INST_LBU: sz = SZ_BYTE;
        INST_LH, INST_LHU: sz = SZ_HALF;
        INST_LW:           sz = SZ_WORD;
        default:           sz = SZ_WORD;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane logic for the LSU: load extraction with sign/zero extension and
// sub-word store merge into a previously read word. Purely combinational.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_ld_data,
  output logic [31:0] o_st_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed byte and halfword of the read word.
  always_comb begin
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  // Extend the selected lane to a full register value.
  always_comb begin
    o_ld_data = ZERO_WORD;
    case (i_funct3)
      INST_LB:  o_ld_data = {{24{w_byte[7]}}, w_byte};
      INST_LBU: o_ld_data = {24'd0, w_byte};
      INST_LH:  o_ld_data = {{16{w_half[15]}}, w_half};
      INST_LHU: o_ld_data = {16'd0, w_half};
      INST_LW:  o_ld_data = i_rdata;
      default:  o_ld_data = i_rdata;
    endcase
  end

  // Overlay the store data onto the read word; full-word stores pass through.
  always_comb begin
    o_st_data = i_rdata;
    case (i_funct3)
      INST_SB: begin
        case (i_addr_lo)
          2'd0:    o_st_data[7:0]   = i_wdata[7:0];
          2'd1:    o_st_data[15:8]  = i_wdata[7:0];
          2'd2:    o_st_data[23:16] = i_wdata[7:0];
          default: o_st_data[31:24] = i_wdata[7:0];
        endcase
      end
      INST_SH: begin
        if (i_addr_lo[1]) o_st_data[31:16] = i_wdata[15:0];
        else              o_st_data[15:0]  = i_wdata[15:0];
      end
      INST_SW: o_st_data = i_wdata;
      default: o_st_data = i_wdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: runs one data-memory transaction per request over a
// req/ack handshake, stalling upstream until completion. Sub-word stores are
// done as read-modify-write. Optional misaligned-access trap enabled by
// defining LSU_MISALIGN_TRAP_EN.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  input  logic              req_we_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [4:0]        rd_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              stall_o,
  output logic              done_o,
  output logic              reg_we_o,
  output logic [4:0]        reg_waddr_o,
  output logic [DATA_W-1:0] reg_wdata_o,
  output logic              misalign_o
);

  lsu_state_t        r_state;
  lsu_state_t        w_next;
  lsu_size_t         w_size;

  logic              r_we;
  logic [2:0]        r_funct3;
  logic [1:0]        r_addr_lo;
  logic [DATA_W-1:0] r_wdata;
  logic [4:0]        r_rd;
  logic [DATA_W-1:0] r_ld_data;

  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic [DATA_W-1:0] w_ld_data;
  logic [DATA_W-1:0] w_st_data;

`ifdef LSU_MISALIGN_TRAP_EN
  logic              r_misalign;
  logic              w_misalign;
`endif

  assign w_size = access_size(req_we_i, funct3_i);

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = ((w_size == SZ_HALF) && addr_i[0]) ||
                      ((w_size == SZ_WORD) && (addr_i[1:0] != 2'b00));
`endif

  lsu_lane u_lane (
    .i_funct3  (r_funct3),
    .i_addr_lo (r_addr_lo),
    .i_rdata   (mem_rdata_i),
    .i_wdata   (r_wdata),
    .o_ld_data (w_ld_data),
    .o_st_data (w_st_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= LSU_IDLE;
    else      r_state <= w_next;
  end

  // Next-state: only full-word stores skip the read phase.
  always_comb begin
    w_next = r_state;
    case (r_state)
      LSU_IDLE: begin
        if (req_valid_i) begin
`ifdef LSU_MISALIGN_TRAP_EN
          if (w_misalign) w_next = LSU_DONE;
          else
`endif
          if (req_we_i && (w_size == SZ_WORD)) w_next = LSU_WR;
          else                                 w_next = LSU_RD;
        end
      end
      LSU_RD:   if (mem_ack_i) w_next = r_we ? LSU_WR : LSU_DONE;
      LSU_WR:   if (mem_ack_i) w_next = LSU_DONE;
      LSU_DONE: w_next = LSU_IDLE;
      default:  w_next = LSU_IDLE;
    endcase
  end

  // Request latch and registered memory interface. Memory outputs are loaded
  // on entry to RD/WR so they stay stable for the whole phase; the merged
  // store word is built from the read data on the RD->WR edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_we        <= 1'b0;
      r_funct3    <= '0;
      r_addr_lo   <= '0;
      r_wdata     <= '0;
      r_rd        <= '0;
      r_ld_data   <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= WRITE_DISABLE;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      r_misalign  <= 1'b0;
`endif
    end else begin
      case (r_state)
        LSU_IDLE: begin
          if (req_valid_i) begin
            r_we      <= req_we_i;
            r_funct3  <= funct3_i;
            r_addr_lo <= addr_i[1:0];
            r_wdata   <= wdata_i;
            r_rd      <= rd_i;
            r_ld_data <= '0;
            if (w_next == LSU_RD) begin
              r_mem_req   <= 1'b1;
              r_mem_we    <= WRITE_DISABLE;
              r_mem_addr  <= {addr_i[ADDR_W-1:2], 2'b00};
              r_mem_wdata <= '0;
            end else if (w_next == LSU_WR) begin
              r_mem_req   <= 1'b1;
              r_mem_we    <= WRITE_ENABLE;
              r_mem_addr  <= {addr_i[ADDR_W-1:2], 2'b00};
              r_mem_wdata <= wdata_i;
            end
          end
`ifdef LSU_MISALIGN_TRAP_EN
          r_misalign <= req_valid_i && w_misalign;
`endif
        end
        LSU_RD: begin
          if (mem_ack_i) begin
            if (r_we) begin
              r_mem_we    <= WRITE_ENABLE;
              r_mem_wdata <= w_st_data;
            end else begin
              r_ld_data   <= w_ld_data;
              r_mem_req   <= 1'b0;
              r_mem_we    <= WRITE_DISABLE;
              r_mem_addr  <= '0;
              r_mem_wdata <= '0;
            end
          end
        end
        LSU_WR: begin
          if (mem_ack_i) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= WRITE_DISABLE;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req_o   = r_mem_req;
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;

  // Pipeline-facing outputs decoded from the current state.
  always_comb begin
    stall_o     = 1'b0;
    done_o      = 1'b0;
    reg_we_o    = 1'b0;
    reg_waddr_o = '0;
    reg_wdata_o = '0;
    misalign_o  = 1'b0;
    case (r_state)
      LSU_IDLE: stall_o = req_valid_i;
      LSU_RD:   stall_o = 1'b1;
      LSU_WR:   stall_o = 1'b1;
      LSU_DONE: begin
        done_o = 1'b1;
        if (!r_we) begin
          reg_we_o    = (r_rd != 5'd0);
          reg_waddr_o = r_rd;
          reg_wdata_o = r_ld_data;
        end
`ifdef LSU_MISALIGN_TRAP_EN
        if (r_misalign) begin
          misalign_o = 1'b1;
          reg_we_o   = 1'b0;
        end
`endif
      end
      default: ;
    endcase
  end

endmodule
